// File: rtl/phy_tx_scheduler_if.sv
// Byte-lane request bus and serializer-side outputs of the PHY TX scheduler.
// master = requesters/serializer side, slave = scheduler.
interface phy_tx_scheduler_if #(
    parameter int NUM_LANES = 4
) ();
    localparam int LW = $clog2(NUM_LANES);

    logic [NUM_LANES*8-1:0] data_in;
    logic [NUM_LANES-1:0]   valid_in;
    logic [NUM_LANES-1:0]   ready;
    logic [7:0]             data_out;
    logic                   valid_out;
    logic [LW-1:0]          lane_out;
    logic                   sync_done;

    modport master (
        output data_in, valid_in,
        input  ready, data_out, valid_out, lane_out, sync_done
    );

    modport slave (
        input  data_in, valid_in,
        output ready, data_out, valid_out, lane_out, sync_done
    );
endinterface

// File: rtl/phy_tx_scheduler.sv
// Shares the PHY TX serializer among NUM_LANES byte requesters: a COM sync
// preamble after reset/enable-low, then round-robin granting one byte per cycle.
module phy_tx_scheduler #(
    parameter int         NUM_LANES = 4,
    parameter int         SYNC_LEN  = 4,
    parameter logic [7:0] COM_SYM   = 8'hBC
) (
    input  logic              i_clk_4f,
    input  logic              i_reset,
    input  logic              i_enable,
    phy_tx_scheduler_if.slave bus
);
    localparam int LW = $clog2(NUM_LANES);

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [7:0]           r_cnt, w_cnt_nxt;
    logic [LW-1:0]        r_ptr, w_ptr_nxt;
    logic [LW-1:0]        r_lane, w_lane_nxt;
    logic [7:0]           r_data, w_data_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_sync_done;
    logic                 w_found;
    logic [LW-1:0]        w_gidx;
    logic [LW-1:0]        w_cand;
    logic [NUM_LANES-1:0] w_ready;
    logic [7:0]           w_bytes [NUM_LANES];

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_bytes
        assign w_bytes[g] = bus.data_in[8*g +: 8];
    end

    // Rotating priority search starting just after the last granted lane.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_cand  = '0;
        for (int unsigned k = 1; k <= NUM_LANES; k++) begin
            w_cand = LW'((32'(r_ptr) + k) % NUM_LANES);
            if (!w_found && bus.valid_in[w_cand]) begin
                w_found = 1'b1;
                w_gidx  = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_lane_nxt  = r_lane;
        w_data_nxt  = COM_SYM;
        w_valid_nxt = 1'b0;
        w_ready     = '0;
        unique case (r_state)
            ST_SYNC: begin
                // Counter pinned at zero while disabled so a full preamble follows enable.
                if (!i_enable) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == 8'(SYNC_LEN - 1)) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_ACTIVE: begin
                if (!i_enable) begin
                    w_state_nxt = ST_SYNC;
                    w_cnt_nxt   = '0;
                end else if (w_found) begin
                    w_ready[w_gidx] = 1'b1;
                    w_data_nxt      = w_bytes[w_gidx];
                    w_valid_nxt     = 1'b1;
                    w_lane_nxt      = w_gidx;
                    w_ptr_nxt       = w_gidx;
                end
            end
        endcase
        if (!i_reset) begin
            w_ready = '0;
        end
    end

    always_ff @(posedge i_clk_4f) begin
        if (!i_reset) begin
            r_state     <= ST_SYNC;
            r_cnt       <= '0;
            r_ptr       <= LW'(NUM_LANES - 1);
            r_lane      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_sync_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            r_lane      <= w_lane_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_sync_done <= (w_state_nxt == ST_ACTIVE);
        end
    end

    assign bus.ready     = w_ready;
    assign bus.data_out  = r_data;
    assign bus.valid_out = r_valid;
    assign bus.lane_out  = r_lane;
    assign bus.sync_done = r_sync_done;
endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Directed bench for phy_tx_scheduler: per-cycle comparison against a
// preamble-countdown / rotation-search model, plus literal expectations.
module tb_phy_tx_scheduler;
    localparam int N    = 4;
    localparam int SLEN = 4;
    localparam logic [7:0] COM = 8'hBC;

    logic clk_4f;
    logic rst_n;
    logic en;
    int   total = 0;
    int   bad   = 0;

    phy_tx_scheduler_if #(.NUM_LANES(N)) bus ();

    phy_tx_scheduler #(
        .NUM_LANES(N),
        .SYNC_LEN (SLEN),
        .COM_SYM  (COM)
    ) dut (
        .i_clk_4f(clk_4f),
        .i_reset (rst_n),
        .i_enable(en),
        .bus     (bus)
    );

    initial begin
        clk_4f = 1'b0;
        forever #5 clk_4f = ~clk_4f;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: link is either counting down remaining preamble bytes or active.
    bit         m_active = 1'b0;
    int         m_left   = SLEN;
    int         m_ptr    = N - 1;
    logic [7:0] m_data   = 8'h00;
    logic       m_valid  = 1'b0;
    int         m_lane   = 0;
    logic       m_sd     = 1'b0;

    function automatic int pick(input logic [N-1:0] vin, input int last);
        for (int k = 1; k <= N; k++) begin
            if (vin[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk_4f) begin
        int g;
        logic [N-1:0] exp_ready;
        chk("data_out",  32'(bus.data_out),  32'(m_data));
        chk("valid_out", 32'(bus.valid_out), 32'(m_valid));
        chk("lane_out",  32'(bus.lane_out),  32'(m_lane));
        chk("sync_done", 32'(bus.sync_done), 32'(m_sd));
        g = pick(bus.valid_in, m_ptr);
        exp_ready = '0;
        if (rst_n && m_active && en && g >= 0) exp_ready[g] = 1'b1;
        chk("ready", 32'(bus.ready), 32'(exp_ready));
        if (!rst_n) begin
            m_active = 1'b0; m_left = SLEN; m_ptr = N - 1;
            m_data = 8'h00; m_valid = 1'b0; m_lane = 0; m_sd = 1'b0;
        end else if (!m_active) begin
            m_data = COM; m_valid = 1'b0;
            if (!en) m_left = SLEN;
            else begin
                m_left--;
                if (m_left == 0) m_active = 1'b1;
            end
            m_sd = m_active;
        end else if (!en) begin
            m_active = 1'b0; m_left = SLEN;
            m_data = COM; m_valid = 1'b0; m_sd = 1'b0;
        end else begin
            if (g >= 0) begin
                m_data = bus.data_in[g*8 +: 8]; m_valid = 1'b1;
                m_lane = g; m_ptr = g;
            end else begin
                m_data = COM; m_valid = 1'b0;
            end
            m_sd = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk_4f);
        #1;
    endtask

    task automatic expect_out(input string name, input logic [7:0] d, input logic v,
                              input int l, input logic sd);
        chk({name, ".data"},  32'(bus.data_out),  32'(d));
        chk({name, ".valid"}, 32'(bus.valid_out), 32'(v));
        chk({name, ".lane"},  32'(bus.lane_out),  32'(l));
        chk({name, ".sd"},    32'(bus.sync_done), 32'(sd));
    endtask

    logic [7:0] rr_bytes [4];
    int         alt_lane [4];

    initial begin
        rr_bytes = '{8'h10, 8'h21, 8'h32, 8'h43};
        alt_lane = '{3, 1, 3, 1};
        rst_n = 1'b0; en = 1'b1;
        bus.valid_in = '0; bus.data_in = '0;

        // 1: reset then preamble
        repeat (3) tick();
        expect_out("rst", 8'h00, 1'b0, 0, 1'b0);
        chk("rst.ready", 32'(bus.ready), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("pre", COM, 1'b0, 0, (i == 3));
        end
        tick();
        expect_out("idle", COM, 1'b0, 0, 1'b1);

        // 2: round robin over all four lanes
        bus.data_in = 32'h43_32_21_10;
        bus.valid_in = 4'hF;
        #1 chk("rr.ready0", 32'(bus.ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk("rr.onehot", 32'($onehot(bus.ready)), 32'h1);
            tick();
            expect_out("rr", rr_bytes[i % 4], 1'b1, i % 4, 1'b1);
        end

        // 3: skip and wrap
        bus.valid_in = 4'b0010;
        tick();
        expect_out("ptr1", 8'h21, 1'b1, 1, 1'b1);
        bus.valid_in = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("skip", (alt_lane[i] == 3) ? 8'h43 : 8'h21, 1'b1, alt_lane[i], 1'b1);
        end
        bus.valid_in = 4'b0000;
        tick();
        expect_out("drop", COM, 1'b0, 1, 1'b1);

        // 4: enable drop mid-stream
        bus.data_in = 32'h43_A5_21_10;
        bus.valid_in = 4'b0100;
        repeat (2) begin
            tick();
            expect_out("a5", 8'hA5, 1'b1, 2, 1'b1);
        end
        en = 1'b0;
        #1 chk("en0.ready", 32'(bus.ready), 32'h0);
        repeat (2) begin
            tick();
            expect_out("en0", COM, 1'b0, 2, 1'b0);
        end
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("resync", COM, 1'b0, 2, (i == 3));
        end
        tick();
        expect_out("resume", 8'hA5, 1'b1, 2, 1'b1);

        // 5: reset mid-operation
        bus.data_in = 32'h33_22_11_7E;
        bus.valid_in = 4'b0001;
        tick();
        expect_out("l0", 8'h7E, 1'b1, 0, 1'b1);
        rst_n = 1'b0;
        #1 chk("rst2.ready", 32'(bus.ready), 32'h0);
        tick();
        expect_out("rst2", 8'h00, 1'b0, 0, 1'b0);
        rst_n = 1'b1;
        bus.valid_in = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("pre2", COM, 1'b0, 0, (i == 3));
        end
        tick();
        expect_out("first", 8'h7E, 1'b1, 0, 1'b1);

        // 6: single lane back-to-back
        bus.valid_in = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            bus.data_in[31:24] = 8'(k);
            tick();
            expect_out("b2b", 8'(k), 1'b1, 3, 1'b1);
        end

        bus.valid_in = '0;
        tick();
        @(negedge clk_4f);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/phy_tx_scheduler.md
Name: phy_tx_scheduler

Overview:
- Sequences and shares the PHY TX serializer among NUM_LANES byte requesters.
- Each clk_4f cycle it presents exactly one byte to the serializer's parallel input: either a granted requester byte (valid_out=1) or the COM idle symbol 8'hBC (valid_out=0).
- After reset, or while enable is low, it forces a sync preamble of COM symbols before any data is granted.
- Round-robin arbitration gives each lane fair access.

Parameters:
- NUM_LANES, 4, number of requesters; legal range 2..8.
- SYNC_LEN, 4, number of consecutive COM bytes sent in SYNC before entering ACTIVE; legal range 1..255.
- COM_SYM, 8'hBC, idle/comma symbol emitted when no data is sent.
- LW, $clog2(NUM_LANES), lane index width (derived; not to be overridden).

Ports:
- clk_4f  input  1  byte clock; the serializer's parallel-load clock.
- reset  input  1  synchronous, active-low; sampled on posedge clk_4f.
- enable  input  1  1 = permit data traffic; 0 = hold link in SYNC.
- data_in  input  NUM_LANES*8  lane i byte on bits [8i+7:8i].
- valid_in  input  NUM_LANES  lane i has a byte to send.
- ready  output  NUM_LANES  one-hot grant, combinational; lane i byte is consumed when valid_in[i] & ready[i] at a clock edge.
- data_out  output  8  registered byte to the serializer.
- valid_out  output  1  registered; 1 = data_out is requester data, 0 = COM idle.
- lane_out  output  LW  registered index of the lane that sourced data_out; holds its last value when valid_out=0.
- sync_done  output  1  registered; 1 while in ACTIVE.

Behaviour:
- Reset (reset=0 at a posedge), regardless of state:
  - state=SYNC; sync counter=0; rr pointer=NUM_LANES-1, so lane 0 has first priority.
  - data_out=8'h00, valid_out=0, lane_out=0, sync_done=0.
  - ready=0 combinationally while reset=0.
- State SYNC:
  - ready=0.
  - Each cycle: data_out<=COM_SYM, valid_out<=0, counter++.
  - When counter==SYNC_LEN-1 and enable=1, next state is ACTIVE and the counter clears.
  - If enable=0, the counter holds at 0, so SYNC_LEN full COM bytes are always sent after enable rises.
- State ACTIVE:
  - sync_done=1.
  - Search lanes starting at (ptr+1) mod NUM_LANES, wrapping; the first lane with valid_in=1 is granted (ready one-hot).
  - On the next edge: data_out<=data_in[granted], valid_out<=1, lane_out<=granted index, ptr<=granted index.
  - No valid lane: ready=0, data_out<=COM_SYM, valid_out<=0, ptr and lane_out unchanged.
- enable=0 in ACTIVE:
  - ready=0 in that same cycle; no byte is consumed.
  - Next state is SYNC with counter=0; data_out<=COM_SYM, valid_out<=0, sync_done<=0.
- Latency: a byte granted at edge N appears on data_out after edge N (one clk_4f cycle). Throughput is one byte per cycle.
- Fairness: a continuously valid lane waits at most NUM_LANES-1 cycles for a grant.
- Simultaneous events:
  - reset has priority over enable and over all arbitration.
  - A single valid lane is granted every cycle (back-to-back).
- valid_in may drop without being granted; no state is retained per lane.
- ready depends only on state, enable, reset, valid_in and ptr. There is no combinational path from data_in to any output other than through the register.

Test Plan:
1. Reset sequence: hold reset=0 for 3 cycles, then release with enable=1 and SYNC_LEN=4, all valid_in=0.
   -> During reset: data_out=8'h00, valid_out=0.
   -> After release: exactly 4 cycles of data_out=8'hBC, valid_out=0; then sync_done=1.
   -> ACTIVE with no requests: data_out=8'hBC, valid_out=0.
2. Round-robin: in ACTIVE, all 4 lanes valid with bytes 8'h10, 8'h21, 8'h32, 8'h43, held for 8 cycles.
   -> data_out sequence 10,21,32,43,10,21,32,43; lane_out sequence 0,1,2,3,0,1,2,3; ready one-hot every cycle.
3. Skip and wrap: valid_in=4'b1010, ptr at lane 1.
   -> Grants go lane 3 then lane 1, alternating; lane_out sequence 3,1,3,1.
   -> Drop to valid_in=0: data_out=8'hBC, valid_out=0, lane_out stays 1.
4. Enable drop mid-traffic: enable=0 for 2 cycles during stream 8'hA5 from lane 2.
   -> ready=0 immediately; data_out=8'hBC, sync_done=0.
   -> After enable returns high: 4 COM cycles, then lane 2 data resumes.
5. Reset mid-operation: assert reset=0 while lane 0 streams 8'h7E.
   -> Next edge: data_out=8'h00, valid_out=0, ready=0.
   -> After release: full sync preamble, and lane 0 is granted first.
6. Single-lane back-to-back: only lane 3 valid with incrementing data 8'h00 to 8'h07.
   -> Grant every cycle; data_out 00..07 with no COM gaps; valid_out=1 throughout.
